// File: rtl/trace_buffer_capture_ctrl.sv
// Trace-buffer write controller: arm/stop, one-shot or circular capture, decimation, status.
// Optional macro TRACE_BUF_TIMESTAMP_EN stamps the pad bits with a capture-relative timestamp.
module trace_buffer_capture_ctrl #(
  parameter int unsigned VECTOR_DATA_WIDTH    = 192,
  parameter int unsigned TRACE_BUF_DATA_WIDTH = 256,
  parameter int unsigned TRACE_BUF_ADDR_WIDTH = 15,
  parameter int unsigned DECIM_WIDTH          = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            arm,
  input  logic                            stop,
  input  logic                            mode_circular,
  input  logic [DECIM_WIDTH-1:0]          decim,
  input  logic                            sample_valid,
  input  logic [VECTOR_DATA_WIDTH-1:0]    sample_data,
  input  logic [31:0]                     host_addr,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addr_out,
  output logic [TRACE_BUF_DATA_WIDTH-1:0] trace_buf_bram_data_in,
  output logic                            trace_buf_we,
  output logic                            trace_buf_en,
  output logic                            capturing,
  output logic                            done,
  output logic                            wrapped,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] wr_ptr,
  output logic [TRACE_BUF_ADDR_WIDTH:0]   wr_count
);

  localparam int unsigned AW    = TRACE_BUF_ADDR_WIDTH;
  localparam int unsigned CW    = TRACE_BUF_ADDR_WIDTH + 1;
  localparam int unsigned DW    = TRACE_BUF_DATA_WIDTH;
  localparam int unsigned PAD_W = TRACE_BUF_DATA_WIDTH - VECTOR_DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                 state;
  logic                   mode_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dcnt;
  logic [DW-1:0]          wdata_c;
  logic                   unused_c;

  assign trace_buf_en = 1'b1;
  assign unused_c     = ^host_addr[31:AW];

`ifdef TRACE_BUF_TIMESTAMP_EN
  generate
    if (PAD_W > 0) begin : g_ts
      logic [PAD_W-1:0] ts;

      // Zero in the first CAPTURE cycle after arm, free-running while capturing.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          ts <= '0;
        end else if (arm) begin
          ts <= '0;
        end else if (state == S_CAPTURE) begin
          ts <= ts + PAD_W'(1);
        end
      end

      assign wdata_c = {ts, sample_data};
    end else begin : g_no_ts
      assign wdata_c = DW'(sample_data);
    end
  endgenerate
`else
  assign wdata_c = DW'(sample_data);
`endif

  // FSM, BRAM port mux and capture status share one register stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                   <= S_IDLE;
      trace_buf_bram_addr_out <= '0;
      trace_buf_bram_data_in  <= '0;
      trace_buf_we            <= 1'b0;
      capturing               <= 1'b0;
      done                    <= 1'b0;
      wrapped                 <= 1'b0;
      wr_ptr                  <= '0;
      wr_count                <= '0;
      dcnt                    <= '0;
      mode_q                  <= 1'b0;
      decim_q                 <= '0;
    end else begin
      trace_buf_we            <= 1'b0;
      trace_buf_bram_addr_out <= host_addr[AW-1:0];

      if (arm) begin
        // Arm has priority over stop and discards any sample in this cycle.
        state     <= S_CAPTURE;
        capturing <= 1'b1;
        done      <= 1'b0;
        wrapped   <= 1'b0;
        wr_ptr    <= '0;
        wr_count  <= '0;
        dcnt      <= '0;
        mode_q    <= mode_circular;
        decim_q   <= decim;
      end else if (state == S_CAPTURE) begin
        if (sample_valid) begin
          if (dcnt == '0) begin
            trace_buf_we            <= 1'b1;
            trace_buf_bram_addr_out <= wr_ptr;
            trace_buf_bram_data_in  <= wdata_c;
            wr_ptr                  <= wr_ptr + AW'(1);
            dcnt                    <= decim_q;
            if (wr_count != DEPTH_C) begin
              wr_count <= wr_count + CW'(1);
            end
            if (&wr_ptr) begin
              if (mode_q) begin
                wrapped <= 1'b1;
              end else begin
                state     <= S_DONE;
                capturing <= 1'b0;
                done      <= 1'b1;
              end
            end
          end else begin
            dcnt <= dcnt - DECIM_WIDTH'(1);
          end
        end
        if (stop) begin
          state     <= S_DONE;
          capturing <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer_capture_ctrl.sv
// Directed bench for trace_buffer_capture_ctrl: scoreboard of expected BRAM writes plus status checks.
module tb_trace_buffer_capture_ctrl;

  typedef struct {
    logic [14:0]  addr;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         arm;
  logic         stop;
  logic         mode_circular;
  logic [7:0]   decim;
  logic         sample_valid;
  logic [191:0] sample_data;
  logic [31:0]  host_addr;
  logic [14:0]  addr_out;
  logic [255:0] data_in;
  logic         we;
  logic         en;
  logic         capturing;
  logic         done;
  logic         wrapped;
  logic [14:0]  wr_ptr;
  logic [15:0]  wr_count;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  trace_buffer_capture_ctrl dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .arm                     (arm),
    .stop                    (stop),
    .mode_circular           (mode_circular),
    .decim                   (decim),
    .sample_valid            (sample_valid),
    .sample_data             (sample_data),
    .host_addr               (host_addr),
    .trace_buf_bram_addr_out (addr_out),
    .trace_buf_bram_data_in  (data_in),
    .trace_buf_we            (we),
    .trace_buf_en            (en),
    .capturing               (capturing),
    .done                    (done),
    .wrapped                 (wrapped),
    .wr_ptr                  (wr_ptr),
    .wr_count                (wr_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [14:0] a, input logic [191:0] d);
    exp_t e;
    e.addr = a;
    e.data = {64'b0, d};
    q.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every write the DUT issues must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", addr_out, data_in);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("write_addr", 256'(addr_out), 256'(e.addr));
        chk("write_data", data_in, e.data);
      end
    end
  end

  initial begin
    rstn = 1'b0; arm = 1'b0; stop = 1'b0; mode_circular = 1'b0; decim = 8'd0;
    sample_valid = 1'b0; sample_data = '0; host_addr = 32'h1234;
    cyc(); cyc();

    // Reset state
    chk("rst_addr", 256'(addr_out), 256'(0));
    chk("rst_we", 256'(we), 256'(0));
    chk("rst_wr_count", 256'(wr_count), 256'(0));
    chk("en_const", 256'(en), 256'(1));

    // Idle host address pass-through
    rstn = 1'b1;
    cyc();
    chk("idle_addr", 256'(addr_out), 256'(16'h1234));
    chk("idle_we", 256'(we), 256'(0));
    chk("idle_done", 256'(done), 256'(0));
    chk("idle_capturing", 256'(capturing), 256'(0));

    // One-shot, no decimation, full buffer
    arm = 1'b1; mode_circular = 1'b0; decim = 8'd0;
    cyc();
    arm = 1'b0;
    chk("os_capturing", 256'(capturing), 256'(1));
    for (int i = 0; i < 32768; i++) begin
      sample_valid = 1'b1;
      sample_data  = 192'(i);
      push(15'(i), 192'(i));
      cyc();
      if (i == 32766) chk("os_not_done_early", 256'(done), 256'(0));
    end
    chk("os_done", 256'(done), 256'(1));
    chk("os_capturing_off", 256'(capturing), 256'(0));
    chk("os_wr_count", 256'(wr_count), 256'(32768));
    chk("os_wr_ptr", 256'(wr_ptr), 256'(0));
    chk("os_wrapped", 256'(wrapped), 256'(0));
    for (int i = 0; i < 4; i++) begin
      sample_data = 192'(i + 40000);
      cyc();
    end
    sample_valid = 1'b0;
    chk("os_queue_drained", 256'(q.size()), 256'(0));

    // Stop outside capture is ignored; host address low bits only
    stop = 1'b1; host_addr = 32'hFFFF_ABCD;
    cyc();
    stop = 1'b0;
    chk("done_hold", 256'(done), 256'(1));
    chk("host_addr_trunc", 256'(addr_out), 256'(15'h2BCD));

    // Decimation by 4
    arm = 1'b1; decim = 8'd3;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1;
      sample_data  = 192'(100 + i);
      if (i % 4 == 0) push(15'(i / 4), 192'(100 + i));
      cyc();
    end
    sample_valid = 1'b0;
    cyc();
    chk("dec_wr_count", 256'(wr_count), 256'(4));
    chk("dec_wr_ptr", 256'(wr_ptr), 256'(4));
    chk("dec_capturing", 256'(capturing), 256'(1));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("dec_stop_done", 256'(done), 256'(1));

    // Circular mode with wrap, stop on an accepted sample
    arm = 1'b1; mode_circular = 1'b1; decim = 8'd0;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 32769; i++) begin
      sample_valid = 1'b1;
      sample_data  = 192'(i);
      push(15'(i), 192'(i));
      cyc();
      if (i == 100)   chk("circ_not_wrapped", 256'(wrapped), 256'(0));
      if (i == 32767) chk("circ_wrapped", 256'(wrapped), 256'(1));
      if (i == 32767) chk("circ_still_capturing", 256'(capturing), 256'(1));
    end
    sample_data = 192'(32769);
    stop = 1'b1;
    push(15'd1, 192'(32769));
    cyc();
    stop = 1'b0; sample_valid = 1'b0;
    chk("circ_done", 256'(done), 256'(1));
    chk("circ_wrapped_end", 256'(wrapped), 256'(1));
    chk("circ_wr_ptr", 256'(wr_ptr), 256'(2));
    chk("circ_wr_count_sat", 256'(wr_count), 256'(32768));

    // Restart by arm while capturing; the arm-cycle sample is dropped
    arm = 1'b1; mode_circular = 1'b0;
    cyc();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data  = 192'(500 + i);
      push(15'(i), 192'(500 + i));
      cyc();
    end
    arm = 1'b1; sample_data = 192'(777);
    cyc();
    arm = 1'b0;
    chk("rearm_wr_count", 256'(wr_count), 256'(0));
    chk("rearm_we", 256'(we), 256'(0));
    sample_data = 192'(888);
    push(15'd0, 192'(888));
    cyc();
    sample_valid = 1'b0;
    chk("rearm_first_count", 256'(wr_count), 256'(1));

    // Mid-capture reset
    sample_valid = 1'b1; sample_data = 192'(999); rstn = 1'b0;
    cyc();
    chk("mid_rst_addr", 256'(addr_out), 256'(0));
    chk("mid_rst_data", data_in, 256'(0));
    chk("mid_rst_we", 256'(we), 256'(0));
    chk("mid_rst_capturing", 256'(capturing), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    chk("mid_rst_wrapped", 256'(wrapped), 256'(0));
    chk("mid_rst_wr_ptr", 256'(wr_ptr), 256'(0));
    chk("mid_rst_wr_count", 256'(wr_count), 256'(0));

    // Arm and stop together: arm wins
    rstn = 1'b1; arm = 1'b1; stop = 1'b1;
    cyc();
    arm = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    chk("armstop_capturing", 256'(capturing), 256'(1));
    chk("armstop_done", 256'(done), 256'(0));
    chk("armstop_no_write", 256'(we), 256'(0));

    cyc(); cyc();
    chk("final_queue_empty", 256'(q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
